// File: rtl/universal_shift_burst.sv
// WIDTH-bit universal shift register with hold/shift/rotate/asr/load/clear modes
// and a burst engine that applies a latched shift mode N times after a start pulse.
module universal_shift_burst #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in,
  input  logic             si,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] out,
  output logic             so,
  output logic             busy,
  output logic             done
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic             done_q, done_d;
  logic [2:0]       act_mode;

  function automatic logic [WIDTH-1:0] apply_mode(input logic [2:0]       m,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] ld,
                                                  input logic             s);
    logic [WIDTH-1:0] r;
    case (m)
      3'b001:  r = {cur[WIDTH-2:0], s};
      3'b010:  r = {s, cur[WIDTH-1:1]};
      3'b011:  r = ld;
      3'b100:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  r = {cur[0], cur[WIDTH-1:1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      3'b111:  r = '0;
      default: r = cur;
    endcase
    return r;
  endfunction

  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
           (m == 3'b101) || (m == 3'b110);
  endfunction

  // While a burst runs, the latched mode owns the datapath and the serial output.
  assign act_mode = (state_q == S_BURST) ? mode_q : sel;
  assign so       = ((act_mode == 3'b001) || (act_mode == 3'b100)) ? out_q[WIDTH-1] : out_q[0];
  assign out      = out_q;
  assign busy     = (state_q == S_BURST);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (state_q == S_BURST) begin
      out_d = apply_mode(mode_q, out_q, in, si);
      rem_d = rem_q - CW'(1);
      if (rem_q == CW'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end else if (start && (cnt != '0) && is_shift_mode(sel)) begin
      // Start edge only arms the engine; the register is left untouched.
      mode_d  = sel;
      rem_d   = cnt;
      state_d = S_BURST;
    end else begin
      out_d = apply_mode(sel, out_q, in, si);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_universal_shift_burst.sv
// Bench for universal_shift_burst: directed scenarios plus a random run,
// all checked against an arithmetic reference model of the register and burst engine.
module tb_universal_shift_burst;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sel;
  logic [W-1:0]  in;
  logic          si;
  logic          start;
  logic [CW-1:0] cnt;
  logic [W-1:0]  out;
  logic          so;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_out;
  logic         m_busy;
  logic         m_done;
  logic [2:0]   m_mode;
  int           m_rem;

  universal_shift_burst #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in(in), .si(si), .start(start),
    .cnt(cnt), .out(out), .so(so), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_op(input logic [2:0] m, input logic [W-1:0] x,
                                          input logic [W-1:0] d, input logic s);
    case (m)
      3'd1:    return (x << 1) | W'(s);
      3'd2:    return (x >> 1) | (W'(s) << (W - 1));
      3'd3:    return d;
      3'd4:    return (x << 1) | (x >> (W - 1));
      3'd5:    return (x >> 1) | (x << (W - 1));
      3'd6:    return $signed(x) >>> 1;
      3'd7:    return '0;
      default: return x;
    endcase
  endfunction

  function automatic logic exp_so();
    logic [2:0] m;
    m = m_busy ? m_mode : sel;
    return (m == 3'd1 || m == 3'd4) ? m_out[W-1] : m_out[0];
  endfunction

  function automatic logic [W+2:0] exp_vec();
    return {m_out, m_busy, m_done, exp_so()};
  endfunction

  task automatic model_reset();
    m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_mode = 3'd0; m_rem = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (m_busy) begin
      m_out  = ref_op(m_mode, m_out, in, si);
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      m_busy = (m_rem != 0);
    end else begin
      m_done = 1'b0;
      if (start && cnt != 0 && sel inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
        m_mode = sel;
        m_rem  = int'(cnt);
        m_busy = 1'b1;
      end else begin
        m_out = ref_op(sel, m_out, in, si);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 3'd0; in = '0; si = 1'b0; start = 1'b0; cnt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out, busy, done} !== {W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_initial: got %h, expected %h", {out, busy, done}, {W'(0), 2'b00});
    end
    @(negedge clk); rst = 1'b0;
    sel = 3'd3; in = W'($urandom_range(1, 255)); tick();
    sel = 3'd4; start = 1'b1; cnt = CW'(6); tick();
    start = 1'b0; tick();
    // Assert reset mid-burst and look before the next clock edge.
    #2; rst = 1'b1; #1;
    model_reset();
    n_checks++;
    if ({out, busy, done} !== {W'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: got %h, expected %h", {out, busy, done}, {W'(0), 2'b00});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_step();
    logic [W-1:0] lit [4] = '{8'h4B, 8'hA5, 8'hD2, 8'hA5};
    logic [2:0]   md  [4] = '{3'd4, 3'd5, 3'd6, 3'd1};
    sel = 3'd3; in = 8'hA5; si = 1'b0; start = 1'b0; tick();
    n_checks++;
    if (out !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_load: got %h, expected %h", out, 8'hA5);
    end
    for (int i = 0; i < 4; i++) begin
      sel = md[i]; si = 1'b1; #1;
      if (i < 2) begin
        n_checks++;
        if (so !== 1'b1) begin
          n_fail++;
          $display("FAIL single_so%0d: got %b, expected 1", i, so);
        end
      end
      tick();
      n_checks++;
      if ({out, busy, done, so} !== exp_vec() || out !== lit[i]) begin
        n_fail++;
        $display("FAIL single_step%0d: got %h, expected %h (out %h)", i,
                 {out, busy, done, so}, exp_vec(), lit[i]);
      end
    end
  endtask

  task automatic test_burst();
    sel = 3'd3; in = 8'h81; tick();
    sel = 3'd1; si = 1'b0; start = 1'b1; cnt = CW'(3); tick();
    n_checks++;
    if ({out, busy, done, so} !== exp_vec() || out !== 8'h81 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_start: got %h, expected %h", {out, busy, done, so}, exp_vec());
    end
    start = 1'b0; sel = 3'd3; in = 8'hFF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if ({out, busy, done, so} !== exp_vec()) begin
        n_fail++;
        $display("FAIL burst_shift%0d: got %h, expected %h", i, {out, busy, done, so}, exp_vec());
      end
    end
    n_checks++;
    if ({out, busy, done} !== {8'h08, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL burst_final: got %h, expected %h", {out, busy, done}, {8'h08, 2'b01});
    end
    sel = 3'd0; tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_done_pulse: got %b, expected 0", done);
    end
  endtask

  task automatic test_rotate_wrap();
    int pulses = 0;
    sel = 3'd3; in = 8'h01; tick();
    sel = 3'd5; start = 1'b1; cnt = CW'(9); tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      si = 1'($urandom);
      tick();
      if (done) pulses++;
      n_checks++;
      if ({out, busy, done, so} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_step%0d: got %h, expected %h", i, {out, busy, done, so}, exp_vec());
      end
    end
    n_checks++;
    if (out !== 8'h80 || pulses != 1) begin
      n_fail++;
      $display("FAIL wrap_final: got out=%h pulses=%0d, expected out=80 pulses=1", out, pulses);
    end
    sel = 3'd0; tick();
  endtask

  task automatic test_ignored_starts();
    int edges = 0;
    sel = 3'd1; si = 1'b1; start = 1'b1; cnt = '0; tick();
    n_checks++;
    if ({out, busy, done, so} !== exp_vec() || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_cnt0: got %h, expected %h", {out, busy, done, so}, exp_vec());
    end
    sel = 3'd3; in = W'($urandom); cnt = CW'(5); tick();
    n_checks++;
    if ({out, busy, done, so} !== exp_vec() || out !== in) begin
      n_fail++;
      $display("FAIL ign_load: got %h, expected %h", {out, busy, done, so}, exp_vec());
    end
    sel = 3'd2; cnt = CW'(4); tick();
    sel = 3'd1; cnt = CW'(7); start = 1'b1;
    while (edges < 20) begin
      si = 1'($urandom);
      tick();
      edges++;
      n_checks++;
      if ({out, busy, done, so} !== exp_vec()) begin
        n_fail++;
        $display("FAIL ign_busy%0d: got %h, expected %h", edges, {out, busy, done, so}, exp_vec());
      end
      if (done) break;
    end
    n_checks++;
    if (edges != 4) begin
      n_fail++;
      $display("FAIL ign_count: got %0d edges, expected 4", edges);
    end
    start = 1'b0; sel = 3'd0; tick();
  endtask

  task automatic test_abort_back_to_back();
    sel = 3'd3; in = W'($urandom); tick();
    sel = 3'd2; si = 1'b1; start = 1'b1; cnt = CW'(5); tick();
    start = 1'b0; tick(); tick();
    #2; rst = 1'b1; #1;
    model_reset();
    n_checks++;
    if ({out, busy, done} !== {W'(0), 2'b00}) begin
      n_fail++;
      $display("FAIL abort: got %h, expected %h", {out, busy, done}, {W'(0), 2'b00});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b, expected 0", done);
    end
    model_edge();
    sel = 3'd3; in = W'($urandom); tick();
    sel = 3'd4; start = 1'b1; cnt = CW'(2); tick();
    sel = 3'd5; cnt = CW'(3);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({out, busy, done, so} !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_step%0d: got %h, expected %h", i, {out, busy, done, so}, exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if ({busy, done} !== 2'b10) begin
          n_fail++;
          $display("FAIL b2b_accept: got %b, expected 10", {busy, done});
        end
        start = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      sel   = 3'($urandom_range(0, 7));
      in    = W'($urandom);
      si    = 1'($urandom);
      start = ($urandom_range(0, 9) < 3);
      cnt   = CW'($urandom_range(0, (1 << CW) - 1));
      tick();
      n_checks++;
      if ({out, busy, done, so} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random%0d: got %h, expected %h", i, {out, busy, done, so}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_burst();
    test_rotate_wrap();
    test_ignored_starts();
    test_abort_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    if (n_fail == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
